fixed_addsub_scheduler: RTL and testbench

Round-robin scheduler that shares one `FixedAddSub` unit among `NUM_REQ` requesters (vertex/ray pipeline stages) with one-operation-per-cycle throughput. It registers the winning operands toward the unit and tracks ownership of each in-flight operation with a tag pipeline. It returns each result to its owner on a shared result bus with a one-hot valid, and flags any mismatch between issued operations and unit responses.

---
 rtl/fixed_addsub_scheduler_pkg.sv | 12 +
 rtl/fixed_addsub_scheduler_if.sv | 33 +++
 rtl/fixed_addsub_scheduler_rr_arbiter_onehot.sv | 34 +++
 rtl/fixed_addsub_scheduler.sv | 73 +++++++
 tb/tb_fixed_addsub_scheduler.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fixed_addsub_scheduler_pkg.sv
// fixed_addsub_scheduler_pkg: shared widths and tag type for the add/sub scheduler
package fixed_addsub_scheduler_pkg;
  localparam int LONG_WIDTH = 64;
  localparam int MAX_REQ = 8;
  // Tag index is sized for the largest supported requester count
  localparam int IDX_W = $clog2(MAX_REQ);
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;
endpackage

// File: rtl/fixed_addsub_scheduler_if.sv
// fixed_addsub_scheduler_if: requester, unit and result signals of the scheduler
interface fixed_addsub_scheduler_if
  import fixed_addsub_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = LONG_WIDTH,
  parameter int CNT_W = 16
);
  logic [NUM_REQ-1:0] iRequest;
  logic [NUM_REQ*WIDTH-1:0] iA;
  logic [NUM_REQ*WIDTH-1:0] iB;
  logic [NUM_REQ-1:0] iOperation;
  logic [NUM_REQ-1:0] oGrant;
  logic [WIDTH-1:0] oA;
  logic [WIDTH-1:0] oB;
  logic oOperation;
  logic oInputReady;
  logic [WIDTH-1:0] iR;
  logic iOutputReady;
  logic [WIDTH-1:0] oResult;
  logic [NUM_REQ-1:0] oResultValid;
  logic oBusy;
  logic oError;
  logic [CNT_W-1:0] oOpCount;
  modport master (
    output iRequest, iA, iB, iOperation, iR, iOutputReady,
    input oGrant, oA, oB, oOperation, oInputReady, oResult, oResultValid, oBusy, oError, oOpCount
  );
  modport slave (
    input iRequest, iA, iB, iOperation, iR, iOutputReady,
    output oGrant, oA, oB, oOperation, oInputReady, oResult, oResultValid, oBusy, oError, oOpCount
  );
endinterface

// File: rtl/fixed_addsub_scheduler_rr_arbiter_onehot.sv
// rr_arbiter_onehot: round-robin one-hot pick starting after the last winner
module rr_arbiter_onehot
  import fixed_addsub_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output idx_t         idx
);
  idx_t last_q, last_d;
  logic any;
  int p;
  // Scan farthest-first so the nearest requester after last_q overwrites
  always_comb begin
    any = 1'b0;
    idx = '0;
    p = 0;
    for (int k = N; k >= 1; k--) begin
      p = (int'(last_q) + k) % N;
      if (|(req & (N'(1) << p))) begin
        any = 1'b1;
        idx = idx_t'(p);
      end
    end
    grant = any ? N'(1) << idx : '0;
    last_d = any ? idx : last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= idx_t'(N - 1);
    else last_q <= last_d;
endmodule

// File: rtl/fixed_addsub_scheduler.sv
// fixed_addsub_scheduler: shares one add/sub unit among requesters, routing results by tag
module fixed_addsub_scheduler
  import fixed_addsub_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = LONG_WIDTH,
  parameter int CNT_W = 16
) (
  input logic Clock,
  input logic Reset,
  fixed_addsub_scheduler_if.slave bus
);
  logic [NUM_REQ-1:0] grant, vld_d, vld_q;
  idx_t win;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q, res_d, res_q;
  logic op_d, op_q, rdy_d, rdy_q, err_d, err_q, route;
  tag_t tag1_d, tag1_q, tag2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  rr_arbiter_onehot #(.N(NUM_REQ)) u_arb (
    .clk(Clock),
    .rst_n(Reset),
    .req(bus.iRequest),
    .grant(grant),
    .idx(win)
  );
  // Stage 1 lines up with oInputReady, stage 2 with the unit's iOutputReady
  always_comb begin
    rdy_d = |grant;
    a_d = rdy_d ? WIDTH'(bus.iA >> (int'(win) * WIDTH)) : a_q;
    b_d = rdy_d ? WIDTH'(bus.iB >> (int'(win) * WIDTH)) : b_q;
    op_d = rdy_d ? |(bus.iOperation & grant) : op_q;
    tag1_d = '{valid: rdy_d, idx: win};
    route = bus.iOutputReady & tag2_q.valid;
    res_d = route ? bus.iR : res_q;
    vld_d = route ? NUM_REQ'(1) << tag2_q.idx : '0;
    err_d = err_q | (bus.iOutputReady ^ tag2_q.valid);
    cnt_d = cnt_q + CNT_W'(rdy_d);
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      rdy_q <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      res_q <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      rdy_q <= rdy_d;
      tag1_q <= tag1_d;
      tag2_q <= tag1_q;
      res_q <= res_d;
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign bus.oGrant = grant;
  assign bus.oA = a_q;
  assign bus.oB = b_q;
  assign bus.oOperation = op_q;
  assign bus.oInputReady = rdy_q;
  assign bus.oResult = res_q;
  assign bus.oResultValid = vld_q;
  assign bus.oBusy = rdy_q | tag1_q.valid | tag2_q.valid;
  assign bus.oError = err_q;
  assign bus.oOpCount = cnt_q;
endmodule

// File: tb/tb_fixed_addsub_scheduler.sv
// tb_fixed_addsub_scheduler: directed checks of arbitration, latency, routing, reset, error and counter wrap
module tb_fixed_addsub_scheduler;
  localparam int N = 4;
  localparam int W = 64;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic unit_rdy, inj;
  logic [W-1:0] unit_r;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] fair_res [4];

  fixed_addsub_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .CNT_W(16)) bus ();
  fixed_addsub_scheduler_if #(.NUM_REQ(N), .WIDTH(W), .CNT_W(4)) bus4 ();

  fixed_addsub_scheduler #(.NUM_REQ(N), .WIDTH(W), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );
  fixed_addsub_scheduler #(.NUM_REQ(N), .WIDTH(W), .CNT_W(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .bus(bus4)
  );

  always #5 Clock = ~Clock;

  // One-cycle add/sub unit, reset with the scheduler
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      unit_rdy <= 1'b0;
      unit_r <= '0;
    end else begin
      unit_rdy <= bus.oInputReady;
      unit_r <= bus.oOperation ? bus.oA - bus.oB : bus.oA + bus.oB;
    end

  assign bus.iOutputReady = unit_rdy | inj;
  assign bus.iR = unit_r;
  assign bus4.iRequest = bus.iRequest;
  assign bus4.iA = bus.iA;
  assign bus4.iB = bus.iB;
  assign bus4.iOperation = bus.iOperation;
  assign bus4.iOutputReady = bus.iOutputReady;
  assign bus4.iR = bus.iR;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic op);
    bus.iA[i*W +: W] = a;
    bus.iB[i*W +: W] = b;
    bus.iOperation[i] = op;
  endtask

  initial begin
    fair_res[0] = 64'd11;
    fair_res[1] = 64'd18;
    fair_res[2] = 64'd33;
    fair_res[3] = 64'd36;
    bus.iRequest = '0;
    bus.iA = '0;
    bus.iB = '0;
    bus.iOperation = '0;
    inj = 1'b0;
    #2;
    chk("rst_oA", bus.oA, 0);
    chk("rst_oB", bus.oB, 0);
    chk("rst_oOperation", bus.oOperation, 0);
    chk("rst_oInputReady", bus.oInputReady, 0);
    chk("rst_oResult", bus.oResult, 0);
    chk("rst_oResultValid", bus.oResultValid, 0);
    chk("rst_oError", bus.oError, 0);
    chk("rst_oOpCount", bus.oOpCount, 0);
    chk("rst_oBusy", bus.oBusy, 0);
    tick(2);
    Reset = 1'b1;

    set_req(2, 64'd5, 64'd3, 1'b1);
    bus.iRequest = 4'b0100;
    #1 chk("single_grant", bus.oGrant, 4'b0100);
    tick();
    bus.iRequest = '0;
    #1;
    chk("single_inrdy", bus.oInputReady, 1);
    chk("single_oA", bus.oA, 5);
    chk("single_oB", bus.oB, 3);
    chk("single_op", bus.oOperation, 1);
    chk("single_busy", bus.oBusy, 1);
    chk("single_nogrant", bus.oGrant, 0);
    tick();
    chk("single_vld_t2", bus.oResultValid, 0);
    tick();
    chk("single_res", bus.oResult, 2);
    chk("single_vld", bus.oResultValid, 4'b0100);
    chk("single_cnt", bus.oOpCount, 1);
    tick();
    chk("single_vld_pulse", bus.oResultValid, 0);
    chk("single_idle", bus.oBusy, 0);

    set_req(0, 64'd3, 64'd5, 1'b1);
    bus.iRequest = 4'b0001;
    #1 chk("wrap_sub_grant", bus.oGrant, 4'b0001);
    tick();
    bus.iRequest = '0;
    tick(2);
    chk("wrap_sub_res", bus.oResult, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_sub_vld", bus.oResultValid, 4'b0001);
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    bus.iRequest = 4'b0001;
    #1 chk("wrap_add_grant", bus.oGrant, 4'b0001);
    tick();
    bus.iRequest = '0;
    tick(2);
    chk("wrap_add_res", bus.oResult, 0);
    chk("wrap_add_vld", bus.oResultValid, 4'b0001);

    tick();
    set_req(1, 64'd10, 64'd1, 1'b0);
    bus.iRequest = 4'b0010;
    #1 chk("mid_grant1", bus.oGrant, 4'b0010);
    tick();
    set_req(3, 64'd20, 64'd2, 1'b0);
    bus.iRequest = 4'b1000;
    #1 chk("mid_grant3", bus.oGrant, 4'b1000);
    tick();
    bus.iRequest = '0;
    Reset = 1'b0;
    #1;
    chk("mid_rst_inrdy", bus.oInputReady, 0);
    chk("mid_rst_oA", bus.oA, 0);
    chk("mid_rst_oB", bus.oB, 0);
    chk("mid_rst_busy", bus.oBusy, 0);
    chk("mid_rst_cnt", bus.oOpCount, 0);
    chk("mid_rst_vld", bus.oResultValid, 0);
    tick(2);
    Reset = 1'b1;

    set_req(0, 64'd10, 64'd1, 1'b0);
    set_req(1, 64'd20, 64'd2, 1'b1);
    set_req(2, 64'd30, 64'd3, 1'b0);
    set_req(3, 64'd40, 64'd4, 1'b1);
    bus.iRequest = 4'b1111;
    for (int k = 0; k <= 10; k++) begin
      if (k == 8) bus.iRequest = '0;
      #1;
      chk($sformatf("fair_grant%0d", k), bus.oGrant, k < 8 ? 64'(1) << (k % 4) : 64'd0);
      chk($sformatf("fair_vld%0d", k), bus.oResultValid, k >= 3 ? 64'(1) << ((k - 3) % 4) : 64'd0);
      if (k >= 3) chk($sformatf("fair_res%0d", k), bus.oResult, fair_res[(k-3)%4]);
      tick();
    end
    chk("fair_cnt", bus.oOpCount, 8);
    chk("fair_cnt4", bus4.oOpCount, 8);
    chk("fair_noerr", bus.oError, 0);
    chk("fair_idle", bus.oBusy, 0);

    inj = 1'b1;
    tick();
    inj = 1'b0;
    #1;
    chk("err_set", bus.oError, 1);
    chk("err_novld", bus.oResultValid, 0);
    chk("err_res_hold", bus.oResult, 36);
    tick(3);
    chk("err_sticky", bus.oError, 1);
    chk("err_novld_later", bus.oResultValid, 0);
    set_req(3, 64'd7, 64'd2, 1'b0);
    bus.iRequest = 4'b1000;
    #1 chk("err_legit_grant", bus.oGrant, 4'b1000);
    tick();
    bus.iRequest = '0;
    tick(2);
    chk("err_legit_res", bus.oResult, 9);
    chk("err_legit_vld", bus.oResultValid, 4'b1000);
    chk("err_still_set", bus.oError, 1);

    tick();
    bus.iRequest = 4'b1111;
    tick(8);
    bus.iRequest = '0;
    #1;
    chk("cnt16_after17", bus.oOpCount, 17);
    chk("cnt4_wrap", bus4.oOpCount, 1);
    chk("cnt_nogrant", bus.oGrant, 0);
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
